// File: rtl/vedic_seq_mult_if.sv
// Handshake bundle for vedic_seq_mult: operand input channel, product output channel, status.
interface vedic_seq_mult_if #(
  parameter int WIDTH = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/vedic_seq_mult.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one 2x2 Vedic cell, one digit pair per cycle,
// shift-accumulated into a 2*WIDTH-bit result.
module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c;
  assign c    = (a[1] & b[0]) & (a[0] & b[1]);
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ c;
  assign p[3] = (a[1] & b[1]) & c;
endmodule

module vedic_seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  vedic_seq_mult_if.slave bus
);
  localparam int N  = WIDTH / 2;
  localparam int NN = N * N;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [PW-1:0]   acc, acc_nxt, prod_reg;
  logic [CW-1:0]   cnt, i_idx, j_idx;
  logic [CW:0]     dig_sum;
  logic [1:0]      a_dig, b_dig;
  logic [3:0]      pp;
  logic            last;

  // cnt walks a-digits in the outer loop, b-digits in the inner loop
  assign i_idx   = cnt / CW'(N);
  assign j_idx   = cnt % CW'(N);
  assign dig_sum = {1'b0, i_idx} + {1'b0, j_idx};
  assign a_dig   = 2'(a_reg >> {i_idx, 1'b0});
  assign b_dig   = 2'(b_reg >> {j_idx, 1'b0});
  assign acc_nxt = acc + (PW'(pp) << {dig_sum, 1'b0});
  assign last    = (cnt == CW'(NN - 1));

  vedic_2x2 u_cell (.a(a_dig), .b(b_dig), .p(pp));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs decode from state only, so no in_valid/out_ready feedthrough.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      prod_reg <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_reg <= bus.a;
          b_reg <= bus.b;
          acc   <= '0;
          cnt   <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last) prod_reg <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.product = prod_reg;
endmodule
